// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush
// insertion, WB-to-ID operand bypass and a saturating stall counter.
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_ID__Valid,
  input  logic [REG_AW-1:0] IF_ID__rs,
  input  logic [REG_AW-1:0] IF_ID__rt,
  input  logic [REG_AW-1:0] IF_ID__rd,
  input  logic [DATA_W-1:0] IF_ID__imm,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic              Flush,
  input  logic              MEM_WB__RegWrite,
  input  logic [REG_AW-1:0] MEM_WB__rWR,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall,
  output logic              ID_EX__Valid,
  output logic              ID_EX__RegWrite,
  output logic              ID_EX__MemRead,
  output logic              ID_EX__MemWrite,
  output logic              ID_EX__MemtoReg,
  output logic              ID_EX__ALUSrc,
  output logic [1:0]        ID_EX__ALUOp,
  output logic [REG_AW-1:0] ID_EX__rs,
  output logic [REG_AW-1:0] ID_EX__rt,
  output logic [REG_AW-1:0] ID_EX__rWR,
  output logic [DATA_W-1:0] ID_EX__A,
  output logic [DATA_W-1:0] ID_EX__B,
  output logic [DATA_W-1:0] ID_EX__imm,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic              hazard;
  logic              bubble;
  logic [REG_AW-1:0] rwr_next;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;

  // Load-use detection; the rt compare is conservative even when rt is not read.
  always_comb begin
    hazard = ID_EX__MemRead && (ID_EX__rt != REG_ZERO) &&
             ((ID_EX__rt == IF_ID__rs) || (ID_EX__rt == IF_ID__rt)) &&
             IF_ID__Valid;
    Stall  = hazard && !Flush;
    bubble = Flush || Stall;
  end

  // Destination select and WB bypass of the register file read data ($0 never bypassed).
  always_comb begin
    if (RegDst) begin
      rwr_next = IF_ID__rd;
    end else begin
      rwr_next = IF_ID__rt;
    end
    if (MEM_WB__RegWrite && (MEM_WB__rWR != REG_ZERO) && (MEM_WB__rWR == IF_ID__rs)) begin
      a_next = WB_Data;
    end else begin
      a_next = RD1;
    end
    if (MEM_WB__RegWrite && (MEM_WB__rWR != REG_ZERO) && (MEM_WB__rWR == IF_ID__rt)) begin
      b_next = WB_Data;
    end else begin
      b_next = RD2;
    end
  end

  // Pipeline register: reset > bubble (flush/stall) > load.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ID_EX__Valid    <= 1'b0;
      ID_EX__RegWrite <= 1'b0;
      ID_EX__MemRead  <= 1'b0;
      ID_EX__MemWrite <= 1'b0;
      ID_EX__MemtoReg <= 1'b0;
      ID_EX__ALUSrc   <= 1'b0;
      ID_EX__ALUOp    <= 2'b00;
      ID_EX__rs       <= REG_ZERO;
      ID_EX__rt       <= REG_ZERO;
      ID_EX__rWR      <= REG_ZERO;
      ID_EX__A        <= DATA_ZERO;
      ID_EX__B        <= DATA_ZERO;
      ID_EX__imm      <= DATA_ZERO;
    end else begin
      ID_EX__Valid <= IF_ID__Valid;
      ID_EX__A     <= a_next;
      ID_EX__B     <= b_next;
      ID_EX__imm   <= IF_ID__imm;
      // An empty ID slot carries no control or register numbers forward.
      if (IF_ID__Valid) begin
        ID_EX__RegWrite <= RegWrite;
        ID_EX__MemRead  <= MemRead;
        ID_EX__MemWrite <= MemWrite;
        ID_EX__MemtoReg <= MemtoReg;
        ID_EX__ALUSrc   <= ALUSrc;
        ID_EX__ALUOp    <= ALUOp;
        ID_EX__rs       <= IF_ID__rs;
        ID_EX__rt       <= IF_ID__rt;
        ID_EX__rWR      <= rwr_next;
      end else begin
        ID_EX__RegWrite <= 1'b0;
        ID_EX__MemRead  <= 1'b0;
        ID_EX__MemWrite <= 1'b0;
        ID_EX__MemtoReg <= 1'b0;
        ID_EX__ALUSrc   <= 1'b0;
        ID_EX__ALUOp    <= 2'b00;
        ID_EX__rs       <= REG_ZERO;
        ID_EX__rt       <= REG_ZERO;
        ID_EX__rWR      <= REG_ZERO;
      end
    end
  end

  // Saturating debug count of stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= {CNT_W{1'b0}};
    end else if (Stall && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_ONE;
    end else begin
      StallCnt <= StallCnt;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage; a second instance with a 4-bit
// counter exercises stall-counter saturation in few cycles.
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        vld;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, rd1, rd2;
  logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
  logic [1:0]  aluop;
  logic        flush;
  logic        wb_rw;
  logic [4:0]  wb_rwr;
  logic [31:0] wb_data;

  logic        stall, o_valid, o_rw, o_mr, o_mw, o_m2r, o_asrc;
  logic [1:0]  o_aluop;
  logic [4:0]  o_rs, o_rt, o_rwr;
  logic [31:0] o_a, o_b, o_imm;
  logic [15:0] o_cnt;

  logic        s_stall, s_valid, s_rw, s_mr, s_mw, s_m2r, s_asrc;
  logic [1:0]  s_aluop;
  logic [4:0]  s_rs, s_rt, s_rwr;
  logic [31:0] s_a, s_b, s_imm;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_hazard_stage dut (
    .clk(clk), .reset(reset), .IF_ID__Valid(vld), .IF_ID__rs(rs), .IF_ID__rt(rt),
    .IF_ID__rd(rd), .IF_ID__imm(imm), .RD1(rd1), .RD2(rd2), .RegDst(regdst),
    .ALUSrc(alusrc), .MemRead(memread), .MemWrite(memwrite), .MemtoReg(memtoreg),
    .RegWrite(regwrite), .ALUOp(aluop), .Flush(flush), .MEM_WB__RegWrite(wb_rw),
    .MEM_WB__rWR(wb_rwr), .WB_Data(wb_data), .Stall(stall), .ID_EX__Valid(o_valid),
    .ID_EX__RegWrite(o_rw), .ID_EX__MemRead(o_mr), .ID_EX__MemWrite(o_mw),
    .ID_EX__MemtoReg(o_m2r), .ID_EX__ALUSrc(o_asrc), .ID_EX__ALUOp(o_aluop),
    .ID_EX__rs(o_rs), .ID_EX__rt(o_rt), .ID_EX__rWR(o_rwr), .ID_EX__A(o_a),
    .ID_EX__B(o_b), .ID_EX__imm(o_imm), .StallCnt(o_cnt)
  );

  id_ex_hazard_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .IF_ID__Valid(vld), .IF_ID__rs(rs), .IF_ID__rt(rt),
    .IF_ID__rd(rd), .IF_ID__imm(imm), .RD1(rd1), .RD2(rd2), .RegDst(regdst),
    .ALUSrc(alusrc), .MemRead(memread), .MemWrite(memwrite), .MemtoReg(memtoreg),
    .RegWrite(regwrite), .ALUOp(aluop), .Flush(flush), .MEM_WB__RegWrite(wb_rw),
    .MEM_WB__rWR(wb_rwr), .WB_Data(wb_data), .Stall(s_stall), .ID_EX__Valid(s_valid),
    .ID_EX__RegWrite(s_rw), .ID_EX__MemRead(s_mr), .ID_EX__MemWrite(s_mw),
    .ID_EX__MemtoReg(s_m2r), .ID_EX__ALUSrc(s_asrc), .ID_EX__ALUOp(s_aluop),
    .ID_EX__rs(s_rs), .ID_EX__rt(s_rt), .ID_EX__rWR(s_rwr), .ID_EX__A(s_a),
    .ID_EX__B(s_b), .ID_EX__imm(s_imm), .StallCnt(s_cnt)
  );

  typedef struct packed {
    logic        valid, rw, mr, mw, m2r, asrc;
    logic [1:0]  aluop;
    logic [4:0]  rs, rt, rwr;
    logic [31:0] a, b, imm;
    logic [15:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0;
  int   bad = 0;
  int   nstall = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    vld = 1'b0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
    regdst = 1'b0; alusrc = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    regwrite = 1'b0; aluop = 2'b00; flush = 1'b0; wb_rw = 1'b0; wb_rwr = 5'd0;
    wb_data = 32'd0; reset = 1'b0;
  endtask

  // One clock: check Stall, predict the ID/EX contents, compare after the edge.
  task automatic cyc();
    exp_t n;
    logic hz, st;
    #1;
    hz = m.mr && (m.rt != 5'd0) && ((m.rt == rs) || (m.rt == rt)) && vld;
    st = hz && !flush;
    check_val("stall", {63'd0, stall}, {63'd0, st});
    check_val("stall_sat", {63'd0, s_stall}, {63'd0, st});
    if (st) nstall++;
    n = '0;
    if (!reset) begin
      n.cnt  = (st && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
      n.scnt = (st && m.scnt != 4'hF) ? m.scnt + 4'd1 : m.scnt;
      if (!(flush || st)) begin
        n.valid = vld;
        n.imm   = imm;
        n.a = (wb_rw && wb_rwr != 5'd0 && wb_rwr == rs) ? wb_data : rd1;
        n.b = (wb_rw && wb_rwr != 5'd0 && wb_rwr == rt) ? wb_data : rd2;
        if (vld) begin
          n.rw = regwrite; n.mr = memread; n.mw = memwrite; n.m2r = memtoreg;
          n.asrc = alusrc; n.aluop = aluop; n.rs = rs; n.rt = rt;
          n.rwr = regdst ? rd : rt;
        end
      end
    end
    q.push_back(n);
    @(posedge clk);
    #1;
    n = q.pop_front();
    check_val("valid", {63'd0, o_valid}, {63'd0, n.valid});
    check_val("ctrl", {58'd0, o_rw, o_mr, o_mw, o_m2r, o_asrc, 1'b0},
              {58'd0, n.rw, n.mr, n.mw, n.m2r, n.asrc, 1'b0});
    check_val("aluop", {62'd0, o_aluop}, {62'd0, n.aluop});
    check_val("regs", {49'd0, o_rs, o_rt, o_rwr}, {49'd0, n.rs, n.rt, n.rwr});
    check_val("a", {32'd0, o_a}, {32'd0, n.a});
    check_val("b", {32'd0, o_b}, {32'd0, n.b});
    check_val("imm", {32'd0, o_imm}, {32'd0, n.imm});
    check_val("cnt", {48'd0, o_cnt}, {48'd0, n.cnt});
    check_val("cnt_sat", {60'd0, s_cnt}, {60'd0, n.scnt});
    m = n;
    @(negedge clk);
  endtask

  task automatic lw8();
    idle(); vld = 1'b1; memread = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; alusrc = 1'b1;
    rs = 5'd1; rt = 5'd8; imm = 32'h10;
  endtask

  task automatic add_rs8();
    idle(); vld = 1'b1; regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10;
    rs = 5'd8; rt = 5'd9; rd = 5'd10; rd1 = 32'h88; rd2 = 32'h99;
  endtask

  int s0;

  initial begin
    idle();
    m = '0;
    @(negedge clk);
    reset = 1'b1; vld = 1'b1; memread = 1'b1; rt = 5'd7; rs = 5'd7; rd1 = 32'hABCD;
    @(posedge clk);
    @(negedge clk);
    rd2 = $urandom; imm = $urandom;
    cyc();
    check_val("rst_cnt", {48'd0, o_cnt}, 64'd0);
    check_val("rst_valid", {63'd0, o_valid}, 64'd0);

    // plain load
    idle(); vld = 1'b1; rs = 5'd3; rt = 5'd4; rd = 5'd5; regdst = 1'b1; regwrite = 1'b1;
    rd1 = 32'h11; rd2 = 32'h22;
    cyc();
    check_val("pl_rwr", {59'd0, o_rwr}, 64'd5);
    check_val("pl_a", {32'd0, o_a}, 64'h11);

    // load-use: one bubble then the add enters with rs=8
    s0 = nstall;
    lw8(); cyc();
    add_rs8(); cyc();
    check_val("lu_bubble_rw", {63'd0, o_rw}, 64'd0);
    check_val("lu_bubble_rwr", {59'd0, o_rwr}, 64'd0);
    add_rs8(); cyc();
    check_val("lu_rs", {59'd0, o_rs}, 64'd8);
    check_val("lu_nstall", nstall - s0, 64'd1);
    check_val("lu_cnt", {48'd0, o_cnt}, 64'd1);

    // load to $0 never stalls
    lw8(); rt = 5'd0; cyc();
    idle(); vld = 1'b1; rs = 5'd0; rt = 5'd0; cyc();

    // WB bypass
    idle(); vld = 1'b1; rs = 5'd16; rt = 5'd2; rd1 = 32'h1; rd2 = 32'h2;
    wb_rw = 1'b1; wb_rwr = 5'd16; wb_data = 32'hDEAD; cyc();
    check_val("byp_a", {32'd0, o_a}, 64'hDEAD);
    wb_rwr = 5'd0; rs = 5'd0; cyc();
    check_val("byp_r0", {32'd0, o_a}, 64'h1);
    wb_rwr = 5'd2; rs = 5'd16; cyc();
    check_val("byp_b", {32'd0, o_b}, 64'hDEAD);

    // flush during hazard: no stall, bubble, counter unchanged
    lw8(); cyc();
    s0 = o_cnt;
    add_rs8(); flush = 1'b1; cyc();
    check_val("fl_valid", {63'd0, o_valid}, 64'd0);
    check_val("fl_cnt", {48'd0, o_cnt}, s0);

    // reset arriving during a stall
    lw8(); cyc();
    add_rs8(); reset = 1'b1; cyc();
    add_rs8(); cyc();
    check_val("rst_mid_rs", {59'd0, o_rs}, 64'd8);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      lw8(); cyc();
      add_rs8(); cyc();
    end
    check_val("sat", {60'd0, s_cnt}, 64'hF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      imm = $urandom; rd1 = $urandom; rd2 = $urandom;
      regdst = 1'($urandom); alusrc = 1'($urandom); memread = 1'($urandom);
      memwrite = 1'($urandom); memtoreg = 1'($urandom); regwrite = 1'($urandom);
      aluop = 2'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 50) == 0);
      wb_rw = 1'($urandom); wb_rwr = 5'($urandom_range(0, 3)); wb_data = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
